// File: rtl/stage_memory_if.sv
// Data-bus interface between the memory stage and the data memory.
// Single outstanding beat: the master raises req and holds we/addr/wdata
// stable until the slave answers with ack (rdata valid with ack on reads).
interface stage_memory_if #(
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [31:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/stage_memory.sv
// Memory stage of the 5-stage vector-capable pipeline.
// Runs scalar (1-beat) or vector (LANES-beat) loads/stores over a one-lane
// req/ack bus, stalls the upstream stages while an access is in flight, and
// owns the MEM/WB pipeline register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses skip the
// bus, retire without writeback and raise the sticky misalign_err flag).
module stage_memory #(
   parameter int DATA_W    = 32,
   parameter int LANES     = 4,
   parameter int ADDR_STEP = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              mem_instr,
   input  logic                     mem_reg_write,
   input  logic                     mem_mem_write,
   input  logic                     mem_mem_read,
   input  logic [1:0]               mem_result_src,
   input  logic                     mem_vector_op,
   input  logic [DATA_W*LANES-1:0]  mem_alu_result,
   input  logic [DATA_W*LANES-1:0]  mem_write_data,
   input  logic [31:0]              mem_pc_plus_4,
   input  logic [DATA_W*LANES-1:0]  mem_imm_ext,
   input  logic [4:0]               mem_rd,
   output logic                     mem_stall,
   stage_memory_if.master           dbus,
   output logic [31:0]              wb_instr,
   output logic                     wb_reg_write,
   output logic [1:0]               wb_result_src,
   output logic                     wb_vector_op,
   output logic [DATA_W*LANES-1:0]  wb_alu_result,
   output logic [DATA_W*LANES-1:0]  wb_read_data,
   output logic [31:0]              wb_pc_plus_4,
   output logic [DATA_W*LANES-1:0]  wb_imm_ext,
   output logic [4:0]               wb_rd,
   output logic                     misalign_err
);

   localparam int VEC_W  = DATA_W * LANES;
   localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [VEC_W-1:0]    rbuf_q, rbuf_d;

   logic                mem_op;
   logic                is_write;
   logic                is_load;
   logic [BEAT_W-1:0]   last_beat;
   logic [31:0]         beat_off;
   logic                misaligned;
   logic                fault_ret;

   logic                bus_req;
   logic                bus_we;
   logic [31:0]         bus_addr;
   logic [DATA_W-1:0]   bus_wdata;

   logic [31:0]         wb_instr_q, wb_instr_d;
   logic                wb_reg_write_q, wb_reg_write_d;
   logic [1:0]          wb_result_src_q, wb_result_src_d;
   logic                wb_vector_op_q, wb_vector_op_d;
   logic [VEC_W-1:0]    wb_alu_result_q, wb_alu_result_d;
   logic [VEC_W-1:0]    wb_read_data_q, wb_read_data_d;
   logic [31:0]         wb_pc_plus_4_q, wb_pc_plus_4_d;
   logic [VEC_W-1:0]    wb_imm_ext_q, wb_imm_ext_d;
   logic [4:0]          wb_rd_q, wb_rd_d;

   // Store wins when both read and write are flagged.
   assign mem_op    = mem_mem_read | mem_mem_write;
   assign is_write  = mem_mem_write;
   assign is_load   = mem_mem_read & ~mem_mem_write;
   assign last_beat = mem_vector_op ? BEAT_W'(LANES - 1) : '0;
   assign beat_off  = 32'(ADDR_STEP) * {{(32-BEAT_W){1'b0}}, beat_q};

`ifdef MEM_ALIGN_CHECK_EN
   logic fault_q, fault_d;
   logic err_q, err_d;

   // Detect misalignment; fault_q marks the DONE cycle of a skipped access.
   always_comb begin
      misaligned = mem_vector_op ? (mem_alu_result[3:0] != 4'd0)
                                 : (mem_alu_result[1:0] != 2'd0);
      fault_d    = (state_q == IDLE) && mem_op && misaligned;
      err_d      = err_q | fault_d;
   end

   // Fault marker and sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fault_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         fault_q <= fault_d;
         err_q   <= err_d;
      end
   end

   assign fault_ret    = fault_q;
   assign misalign_err = err_q;
`else
   assign misaligned   = 1'b0;
   assign fault_ret    = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Access sequencer: next state, beat counter, read capture, bus drive, stall.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      rbuf_d    = rbuf_q;
      mem_stall = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      unique case (state_q)
         IDLE: begin
            if (mem_op) begin
               mem_stall = 1'b1;
               beat_d    = '0;
               state_d   = misaligned ? DONE : BUSY;
            end
         end
         BUSY: begin
            // Outputs depend only on beat_q and the held EX/MEM inputs, so
            // they stay stable across wait cycles.
            mem_stall = 1'b1;
            bus_req   = 1'b1;
            bus_we    = is_write;
            bus_addr  = mem_alu_result[31:0] + beat_off;
            bus_wdata = mem_write_data[beat_q*DATA_W +: DATA_W];
            if (dbus.ack) begin
               rbuf_d[beat_q*DATA_W +: DATA_W] = dbus.rdata;
               if (beat_q == last_beat) begin
                  state_d = DONE;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Nothing is stalled or requested while reset is held.
      if (!reset) begin
         mem_stall = 1'b0;
         bus_req   = 1'b0;
         bus_we    = 1'b0;
         bus_addr  = '0;
         bus_wdata = '0;
      end
   end

   assign dbus.req   = bus_req;
   assign dbus.we    = bus_we;
   assign dbus.addr  = bus_addr;
   assign dbus.wdata = bus_wdata;

   // Sequencer state; a reset mid-access abandons it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         rbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // MEM/WB next value: pass through when not stalled, otherwise a bubble.
   always_comb begin
      wb_instr_d      = '0;
      wb_reg_write_d  = 1'b0;
      wb_result_src_d = '0;
      wb_vector_op_d  = 1'b0;
      wb_alu_result_d = '0;
      wb_read_data_d  = '0;
      wb_pc_plus_4_d  = '0;
      wb_imm_ext_d    = '0;
      wb_rd_d         = '0;
      if (!mem_stall) begin
         wb_instr_d      = mem_instr;
         wb_reg_write_d  = mem_reg_write & ~fault_ret;
         wb_result_src_d = mem_result_src;
         wb_vector_op_d  = mem_vector_op;
         wb_alu_result_d = mem_alu_result;
         wb_pc_plus_4_d  = mem_pc_plus_4;
         wb_imm_ext_d    = mem_imm_ext;
         wb_rd_d         = mem_rd;
         // An unstalled load is always in DONE, so rbuf_q holds its data.
         if (is_load && !fault_ret) begin
            wb_read_data_d = mem_vector_op ? rbuf_q
                           : {{(VEC_W-DATA_W){1'b0}}, rbuf_q[DATA_W-1:0]};
         end
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wb_instr_q      <= '0;
         wb_reg_write_q  <= 1'b0;
         wb_result_src_q <= '0;
         wb_vector_op_q  <= 1'b0;
         wb_alu_result_q <= '0;
         wb_read_data_q  <= '0;
         wb_pc_plus_4_q  <= '0;
         wb_imm_ext_q    <= '0;
         wb_rd_q         <= '0;
      end else begin
         wb_instr_q      <= wb_instr_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_result_src_q <= wb_result_src_d;
         wb_vector_op_q  <= wb_vector_op_d;
         wb_alu_result_q <= wb_alu_result_d;
         wb_read_data_q  <= wb_read_data_d;
         wb_pc_plus_4_q  <= wb_pc_plus_4_d;
         wb_imm_ext_q    <= wb_imm_ext_d;
         wb_rd_q         <= wb_rd_d;
      end
   end

   assign wb_instr      = wb_instr_q;
   assign wb_reg_write  = wb_reg_write_q;
   assign wb_result_src = wb_result_src_q;
   assign wb_vector_op  = wb_vector_op_q;
   assign wb_alu_result = wb_alu_result_q;
   assign wb_read_data  = wb_read_data_q;
   assign wb_pc_plus_4  = wb_pc_plus_4_q;
   assign wb_imm_ext    = wb_imm_ext_q;
   assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_stage_memory.sv
// Directed testbench for stage_memory: scalar/vector loads and stores with
// wait states, back-to-back ALU ops, reset mid-access and alignment handling
// (expectations follow MEM_ALIGN_CHECK_EN when it is defined).
module tb_stage_memory;

   logic          clk;
   logic          reset;
   logic [31:0]   mem_instr;
   logic          mem_reg_write;
   logic          mem_mem_write;
   logic          mem_mem_read;
   logic [1:0]    mem_result_src;
   logic          mem_vector_op;
   logic [127:0]  mem_alu_result;
   logic [127:0]  mem_write_data;
   logic [31:0]   mem_pc_plus_4;
   logic [127:0]  mem_imm_ext;
   logic [4:0]    mem_rd;
   logic          mem_stall;
   logic [31:0]   wb_instr;
   logic          wb_reg_write;
   logic [1:0]    wb_result_src;
   logic          wb_vector_op;
   logic [127:0]  wb_alu_result;
   logic [127:0]  wb_read_data;
   logic [31:0]   wb_pc_plus_4;
   logic [127:0]  wb_imm_ext;
   logic [4:0]    wb_rd;
   logic          misalign_err;

   int n_vec = 0;
   int n_err = 0;

   // Results recorded by run_op for the scenario tasks to judge.
   int          stall_cnt, req_cnt, beats, early_rw, stable_err;
   bit          timed_out;
   logic [31:0] addr_log [8];
   logic [31:0] wdata_log [8];
   logic        we_log [8];
   logic [31:0] rd_tab [4];

   stage_memory_if #(.DATA_W(32)) dbus ();

   stage_memory #(.DATA_W(32), .LANES(4), .ADDR_STEP(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_instr      (mem_instr),
      .mem_reg_write  (mem_reg_write),
      .mem_mem_write  (mem_mem_write),
      .mem_mem_read   (mem_mem_read),
      .mem_result_src (mem_result_src),
      .mem_vector_op  (mem_vector_op),
      .mem_alu_result (mem_alu_result),
      .mem_write_data (mem_write_data),
      .mem_pc_plus_4  (mem_pc_plus_4),
      .mem_imm_ext    (mem_imm_ext),
      .mem_rd         (mem_rd),
      .mem_stall      (mem_stall),
      .dbus           (dbus),
      .wb_instr       (wb_instr),
      .wb_reg_write   (wb_reg_write),
      .wb_result_src  (wb_result_src),
      .wb_vector_op   (wb_vector_op),
      .wb_alu_result  (wb_alu_result),
      .wb_read_data   (wb_read_data),
      .wb_pc_plus_4   (wb_pc_plus_4),
      .wb_imm_ext     (wb_imm_ext),
      .wb_rd          (wb_rd),
      .misalign_err   (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle_inputs();
      mem_instr      = '0;
      mem_reg_write  = 1'b0;
      mem_mem_write  = 1'b0;
      mem_mem_read   = 1'b0;
      mem_result_src = '0;
      mem_vector_op  = 1'b0;
      mem_alu_result = '0;
      mem_write_data = '0;
      mem_pc_plus_4  = '0;
      mem_imm_ext    = '0;
      mem_rd         = '0;
   endtask

   // Bus slave + observer. Called at a negedge with the op already driven;
   // acks each beat after nwait wait cycles and returns at the negedge that
   // follows the first unstalled cycle (the MEM/WB load edge).
   task automatic run_op(input int nwait);
      int          cyc = 0;
      int          wcnt = 0;
      bit          done = 0;
      logic        prev_req = 1'b0;
      logic        prev_ack = 1'b0;
      logic        prev_we = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [31:0] prev_wdata = '0;
      stall_cnt = 0; req_cnt = 0; beats = 0; early_rw = 0; stable_err = 0; timed_out = 0;
      while (!done) begin
         dbus.ack = 1'b0;
         #1;
         if (wb_reg_write || wb_instr != 32'd0) early_rw++;
         if (mem_stall) stall_cnt++;
         if (prev_req && !prev_ack &&
             (!dbus.req || dbus.addr !== prev_addr || dbus.we !== prev_we || dbus.wdata !== prev_wdata))
            stable_err++;
         if (dbus.req) begin
            req_cnt++;
            if (wcnt == nwait) begin
               dbus.ack   = 1'b1;
               dbus.rdata = rd_tab[beats % 4];
               if (beats < 8) begin
                  addr_log[beats]  = dbus.addr;
                  wdata_log[beats] = dbus.wdata;
                  we_log[beats]    = dbus.we;
               end
               beats++;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
         prev_req   = dbus.req;
         prev_ack   = dbus.ack;
         prev_we    = dbus.we;
         prev_addr  = dbus.addr;
         prev_wdata = dbus.wdata;
         if (!mem_stall) done = 1;
         cyc++;
         if (cyc > 60) begin
            timed_out = 1;
            done = 1;
         end
         @(negedge clk);
      end
      dbus.ack = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_alu_result = 128'h100;
      #1;
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_forced got %b want 0", mem_stall); end
      n_vec++; if (dbus.req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", dbus.req); end
      n_vec++; if (dbus.addr !== 32'd0) begin n_err++; $display("FAIL rst_addr got %h want 0", dbus.addr); end
      @(negedge clk);
      #1;
      n_vec++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL rst_wb_reg_write got %b want 0", wb_reg_write); end
      n_vec++; if (wb_alu_result !== 128'd0) begin n_err++; $display("FAIL rst_wb_alu got %h want 0", wb_alu_result); end
      n_vec++; if (wb_read_data !== 128'd0) begin n_err++; $display("FAIL rst_wb_rdata got %h want 0", wb_read_data); end
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b want 0", misalign_err); end
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      #1;
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL post_rst_stall got %b want 0", mem_stall); end
   endtask

   task automatic test_scalar_load();
      @(negedge clk);
      idle_inputs();
      mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result_src = 2'd1;
      mem_alu_result = 128'h100; mem_instr = 32'h1000_2283;
      rd_tab[0] = 32'hDEAD_BEEF;
      run_op(2);
      idle_inputs();
      #1;
      n_vec++; if (timed_out) begin n_err++; $display("FAIL sl_timeout got 1 want 0"); end
      n_vec++; if (stall_cnt !== 4) begin n_err++; $display("FAIL sl_stall_cycles got %0d want 4", stall_cnt); end
      n_vec++; if (req_cnt !== 3) begin n_err++; $display("FAIL sl_req_cycles got %0d want 3", req_cnt); end
      n_vec++; if (beats !== 1) begin n_err++; $display("FAIL sl_beats got %0d want 1", beats); end
      n_vec++; if (addr_log[0] !== 32'h100) begin n_err++; $display("FAIL sl_addr got %h want 00000100", addr_log[0]); end
      n_vec++; if (we_log[0] !== 1'b0) begin n_err++; $display("FAIL sl_we got %b want 0", we_log[0]); end
      n_vec++; if (stable_err !== 0) begin n_err++; $display("FAIL sl_bus_stable got %0d want 0", stable_err); end
      n_vec++; if (early_rw !== 0) begin n_err++; $display("FAIL sl_bubble got %0d want 0", early_rw); end
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("FAIL sl_wb_reg_write got %b want 1", wb_reg_write); end
      n_vec++; if (wb_read_data !== 128'hDEAD_BEEF) begin n_err++; $display("FAIL sl_rdata got %h want %h", wb_read_data, 128'hDEAD_BEEF); end
      n_vec++; if (wb_rd !== 5'd5) begin n_err++; $display("FAIL sl_wb_rd got %0d want 5", wb_rd); end
      n_vec++; if (wb_result_src !== 2'd1) begin n_err++; $display("FAIL sl_wb_src got %0d want 1", wb_result_src); end
      @(negedge clk);
      #1;
      n_vec++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL sl_single_retire got %b want 0", wb_reg_write); end
   endtask

   task automatic test_vector_store();
      @(negedge clk);
      idle_inputs();
      // Read also flagged: the write must take priority.
      mem_mem_write = 1'b1; mem_mem_read = 1'b1; mem_vector_op = 1'b1;
      mem_alu_result = 128'h200; mem_instr = 32'h0020_A027;
      mem_write_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      run_op(0);
      idle_inputs();
      #1;
      n_vec++; if (timed_out) begin n_err++; $display("FAIL vs_timeout got 1 want 0"); end
      n_vec++; if (stall_cnt !== 5) begin n_err++; $display("FAIL vs_stall_cycles got %0d want 5", stall_cnt); end
      n_vec++; if (beats !== 4) begin n_err++; $display("FAIL vs_beats got %0d want 4", beats); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (addr_log[i] !== 32'h200 + 32'(4*i)) begin n_err++; $display("FAIL vs_addr%0d got %h want %h", i, addr_log[i], 32'h200 + 32'(4*i)); end
         n_vec++; if (wdata_log[i] !== 32'h1111_1111 * 32'(i+1)) begin n_err++; $display("FAIL vs_wdata%0d got %h want %h", i, wdata_log[i], 32'h1111_1111 * 32'(i+1)); end
         n_vec++; if (we_log[i] !== 1'b1) begin n_err++; $display("FAIL vs_we%0d got %b want 1", i, we_log[i]); end
      end
      n_vec++; if (early_rw !== 0) begin n_err++; $display("FAIL vs_bubble got %0d want 0", early_rw); end
      n_vec++; if (wb_instr !== 32'h0020_A027) begin n_err++; $display("FAIL vs_retire got %h want 0020a027", wb_instr); end
      n_vec++; if (wb_read_data !== 128'd0) begin n_err++; $display("FAIL vs_rdata got %h want 0", wb_read_data); end
      @(negedge clk);
      #1;
      n_vec++; if (wb_instr !== 32'd0) begin n_err++; $display("FAIL vs_single_retire got %h want 0", wb_instr); end
   endtask

   task automatic test_vector_load();
      @(negedge clk);
      idle_inputs();
      mem_mem_read = 1'b1; mem_vector_op = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd9;
      mem_alu_result = 128'h300; mem_pc_plus_4 = 32'h0000_0404;
      mem_imm_ext = 128'hCAFE_0000_0000_0000_0000_0000_0000_0123;
      rd_tab[0] = 32'd1; rd_tab[1] = 32'd2; rd_tab[2] = 32'd3; rd_tab[3] = 32'd4;
      run_op(1);
      idle_inputs();
      #1;
      n_vec++; if (timed_out) begin n_err++; $display("FAIL vl_timeout got 1 want 0"); end
      n_vec++; if (stall_cnt !== 9) begin n_err++; $display("FAIL vl_stall_cycles got %0d want 9", stall_cnt); end
      n_vec++; if (req_cnt !== 8) begin n_err++; $display("FAIL vl_req_cycles got %0d want 8", req_cnt); end
      n_vec++; if (stable_err !== 0) begin n_err++; $display("FAIL vl_bus_stable got %0d want 0", stable_err); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (addr_log[i] !== 32'h300 + 32'(4*i)) begin n_err++; $display("FAIL vl_addr%0d got %h want %h", i, addr_log[i], 32'h300 + 32'(4*i)); end
         n_vec++; if (we_log[i] !== 1'b0) begin n_err++; $display("FAIL vl_we%0d got %b want 0", i, we_log[i]); end
      end
      n_vec++; if (wb_read_data !== 128'h00000004_00000003_00000002_00000001) begin n_err++; $display("FAIL vl_rdata got %h want 00000004000000030000000200000001", wb_read_data); end
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("FAIL vl_wb_reg_write got %b want 1", wb_reg_write); end
      n_vec++; if (wb_vector_op !== 1'b1) begin n_err++; $display("FAIL vl_wb_vec got %b want 1", wb_vector_op); end
      n_vec++; if (wb_pc_plus_4 !== 32'h0000_0404) begin n_err++; $display("FAIL vl_wb_pc got %h want 00000404", wb_pc_plus_4); end
      n_vec++; if (wb_imm_ext !== 128'hCAFE_0000_0000_0000_0000_0000_0000_0123) begin n_err++; $display("FAIL vl_wb_imm got %h want cafe...0123", wb_imm_ext); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      idle_inputs();
      mem_reg_write = 1'b1; mem_rd = 5'd1; mem_alu_result = 128'h11;
      #1;
      n_vec++; if (mem_stall !== 1'b0 || dbus.req !== 1'b0) begin n_err++; $display("FAIL b2b_stall0 got stall=%b req=%b want 0/0", mem_stall, dbus.req); end
      @(negedge clk);
      mem_rd = 5'd2; mem_alu_result = 128'h22;
      #1;
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall1 got %b want 0", mem_stall); end
      n_vec++; if (wb_rd !== 5'd1) begin n_err++; $display("FAIL b2b_rd1 got %0d want 1", wb_rd); end
      n_vec++; if (wb_alu_result !== 128'h11) begin n_err++; $display("FAIL b2b_alu1 got %h want 11", wb_alu_result); end
      @(negedge clk);
      mem_rd = 5'd3; mem_alu_result = 128'h33;
      #1;
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall2 got %b want 0", mem_stall); end
      n_vec++; if (wb_rd !== 5'd2) begin n_err++; $display("FAIL b2b_rd2 got %0d want 2", wb_rd); end
      @(negedge clk);
      idle_inputs();
      #1;
      n_vec++; if (wb_rd !== 5'd3) begin n_err++; $display("FAIL b2b_rd3 got %0d want 3", wb_rd); end
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("FAIL b2b_rw3 got %b want 1", wb_reg_write); end
      n_vec++; if (wb_read_data !== 128'd0) begin n_err++; $display("FAIL b2b_rdata got %h want 0", wb_read_data); end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      idle_inputs();
      mem_mem_read = 1'b1; mem_vector_op = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd7;
      mem_alu_result = 128'h400;
      dbus.ack = 1'b0;
      @(negedge clk);
      dbus.ack = 1'b1; dbus.rdata = 32'h5555_0000;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_vec++; if (dbus.addr !== 32'h408) begin n_err++; $display("FAIL rm_beat2_addr got %h want 00000408", dbus.addr); end
      reset = 1'b0;
      #1;
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rm_stall_in_reset got %b want 0", mem_stall); end
      @(negedge clk);
      reset = 1'b1;
      dbus.ack = 1'b0;
      idle_inputs();
      #1;
      n_vec++; if (dbus.req !== 1'b0) begin n_err++; $display("FAIL rm_req got %b want 0", dbus.req); end
      n_vec++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL rm_wb_reg_write got %b want 0", wb_reg_write); end
      n_vec++; if (mem_stall !== 1'b0) begin n_err++; $display("FAIL rm_stall got %b want 0", mem_stall); end
      @(negedge clk);
      mem_mem_read = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd8; mem_alu_result = 128'h500;
      rd_tab[0] = 32'h1234_5678;
      run_op(0);
      idle_inputs();
      #1;
      n_vec++; if (timed_out) begin n_err++; $display("FAIL rm_next_timeout got 1 want 0"); end
      n_vec++; if (stall_cnt !== 2) begin n_err++; $display("FAIL rm_next_stall got %0d want 2", stall_cnt); end
      n_vec++; if (req_cnt !== 1 || addr_log[0] !== 32'h500) begin n_err++; $display("FAIL rm_next_bus got req=%0d addr=%h want 1/00000500", req_cnt, addr_log[0]); end
      n_vec++; if (wb_read_data !== 128'h1234_5678) begin n_err++; $display("FAIL rm_next_rdata got %h want 12345678", wb_read_data); end
      n_vec++; if (wb_reg_write !== 1'b1 || wb_rd !== 5'd8) begin n_err++; $display("FAIL rm_next_retire got rw=%b rd=%0d want 1/8", wb_reg_write, wb_rd); end
   endtask

   task automatic test_alignment();
      @(negedge clk);
      idle_inputs();
      mem_mem_read = 1'b1; mem_vector_op = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd4;
      mem_alu_result = 128'h204;
      rd_tab[0] = 32'd5; rd_tab[1] = 32'd6; rd_tab[2] = 32'd7; rd_tab[3] = 32'd8;
      run_op(0);
      idle_inputs();
      #1;
      n_vec++; if (timed_out) begin n_err++; $display("FAIL al_timeout got 1 want 0"); end
`ifdef MEM_ALIGN_CHECK_EN
      n_vec++; if (req_cnt !== 0) begin n_err++; $display("FAIL al_no_req got %0d want 0", req_cnt); end
      n_vec++; if (stall_cnt !== 1) begin n_err++; $display("FAIL al_stall got %0d want 1", stall_cnt); end
      n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL al_err got %b want 1", misalign_err); end
      n_vec++; if (wb_reg_write !== 1'b0) begin n_err++; $display("FAIL al_wb_reg_write got %b want 0", wb_reg_write); end
      repeat (3) @(negedge clk);
      #1;
      n_vec++; if (misalign_err !== 1'b1) begin n_err++; $display("FAIL al_sticky got %b want 1", misalign_err); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL al_clear got %b want 0", misalign_err); end
`else
      n_vec++; if (req_cnt !== 4) begin n_err++; $display("FAIL al_req got %0d want 4", req_cnt); end
      for (int i = 0; i < 4; i++) begin
         n_vec++; if (addr_log[i] !== 32'h204 + 32'(4*i)) begin n_err++; $display("FAIL al_addr%0d got %h want %h", i, addr_log[i], 32'h204 + 32'(4*i)); end
      end
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL al_err got %b want 0", misalign_err); end
      n_vec++; if (wb_reg_write !== 1'b1) begin n_err++; $display("FAIL al_wb_reg_write got %b want 1", wb_reg_write); end
      n_vec++; if (wb_read_data !== 128'h00000008_00000007_00000006_00000005) begin n_err++; $display("FAIL al_rdata got %h want 00000008000000070000000600000005", wb_read_data); end
`endif
   endtask

   initial begin
      reset      = 1'b0;
      dbus.ack   = 1'b0;
      dbus.rdata = '0;
      idle_inputs();
      test_reset();
      test_scalar_load();
      test_vector_store();
      test_vector_load();
      test_back_to_back();
      test_reset_mid_access();
      test_alignment();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
